// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-organised data memory for the MIPS datapath memory stage. Each
//   load/store request is sampled in IDLE. It is answered LATENCY edges later
//   with a one-cycle ready pulse, so the control sequencer can stall on it.
//
//   Parameters
//     DEPTH_LOG2 : word address bits (2**DEPTH_LOG2 words of 32 bits)
//     LATENCY    : edges from request sample to ready rise, legal 1..15
//
//   Ports
//     clk     : clock, rising edge
//     rst     : asynchronous active-high reset
//     LeerMem : read request
//     EscrMem : write request
//     addr    : byte address, word index addr[DEPTH_LOG2+1:2]
//     dataw   : store data
//     be      : store byte enables (only with DATAMEM_BYTE_EN)
//     datard  : registered read data, held until the next good read
//     ready   : one-cycle completion pulse
//     err     : error flag, qualified by ready
//
//   Optional feature macro: DATAMEM_BYTE_EN (per-byte store enables)
//
//   state | meaning
//   IDLE  | waiting for LeerMem/EscrMem
//   WAIT  | latency countdown; access performed when counter is 0
//   DONE  | ready pulse, requests ignored
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LeerMem,
  input  logic        EscrMem,
  input  logic [31:0] addr,
  input  logic [31:0] dataw,
`ifdef DATAMEM_BYTE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] datard,
  output logic        ready,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  lat_rd, lat_wr;
  logic [31:0]           lat_addr, lat_data;
`ifdef DATAMEM_BYTE_EN
  logic [3:0]            lat_be;
`endif
  logic                  err_q;
  logic                  access;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  req;

  logic [31:0] mem [2**DEPTH_LOG2];

  assign req = LeerMem | EscrMem;
  assign idx = lat_addr[DEPTH_LOG2+1:2];

  // Checks on the latched request, in priority order. The result is a
  // single flag, so the order only matters for documentation.
  assign acc_err = (lat_rd & lat_wr)
                 | (lat_addr[1:0] != 2'b00)
                 | ((lat_addr >> (DEPTH_LOG2 + 2)) != 32'h0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      IDLE: if (req) state_nxt = WAIT;
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          access    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 4'd0;
      lat_rd   <= 1'b0;
      lat_wr   <= 1'b0;
      lat_addr <= 32'h0;
      lat_data <= 32'h0;
`ifdef DATAMEM_BYTE_EN
      lat_be   <= 4'h0;
`endif
      datard   <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        lat_rd   <= LeerMem;
        lat_wr   <= EscrMem;
        lat_addr <= addr;
        lat_data <= dataw;
`ifdef DATAMEM_BYTE_EN
        lat_be   <= be;
`endif
        cnt      <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q <= acc_err;
        if (!acc_err && lat_rd) datard <= mem[idx];
      end
    end
  end

  // The array is not reset. A reset during WAIT returns state to IDLE
  // before the access edge, so an aborted store never reaches the array.
  always_ff @(posedge clk) begin
    if (access && !acc_err && lat_wr) begin
`ifdef DATAMEM_BYTE_EN
      for (int i = 0; i < 4; i++)
        if (lat_be[i]) mem[idx][8*i +: 8] <= lat_data[8*i +: 8];
`else
      mem[idx] <= lat_data;
`endif
    end
  end

  assign ready = (state == DONE);
  assign err   = ready & err_q;

endmodule
